// File: rtl/hex_display_scanner_pkg.sv
// Shared constants for the hex display scanner and its helpers.
// Nibble width, default digit count and the all-off anode pattern.
package hex_display_scanner_pkg;

  localparam int NIB_W      = 4;
  localparam int DIGITS_DEF = 4;
  localparam int MAX_DIGITS = 8;

  // Active-low anodes: all ones turns every digit off.
  function automatic logic [MAX_DIGITS-1:0] an_all_off();
    return '1;
  endfunction

endpackage

// File: rtl/hex_display_scanner_scan_timer.sv
// Refresh counter plus digit index for the display scanner.
// Ports: clk_i, rst_i (sync, high) -> idx_o, frame_start_o.
module scan_timer #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  localparam int CW = $clog2(REFRESH_DIV),
  localparam int IW = $clog2(DIGITS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic [IW-1:0] idx_o,
  output logic          frame_start_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          tc;

  assign tc = (cnt_q == CW'(REFRESH_DIV - 1));

  always_comb begin
    cnt_d = tc ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    if (tc) begin
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // First cycle of digit 0: after a wrap or straight out of reset.
  assign idx_o         = idx_q;
  assign frame_start_o = (idx_q == '0) && (cnt_q == '0);

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexes a hex value onto a common-anode 7-segment bank.
// Ports: clk, rst, load, value, dp, en, blank_lz -> nibble, an_n, dp_n, frame_tick, pending.
module hex_display_scanner
  import hex_display_scanner_pkg::*;
#(
  parameter int DIGITS      = DIGITS_DEF,
  parameter int REFRESH_DIV = 50000,
  localparam int IW = $clog2(DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [NIB_W*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]       dp,
  input  logic                    en,
  input  logic                    blank_lz,
  output logic [NIB_W-1:0]        nibble,
  output logic [DIGITS-1:0]       an_n,
  output logic                    dp_n,
  output logic                    frame_tick,
  output logic                    pending
);

  localparam logic [DIGITS-1:0] AN_OFF = DIGITS'(an_all_off());

  logic [IW-1:0] idx;
  logic          frame_start;

  scan_timer #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_timer (
    .clk_i         (clk),
    .rst_i         (rst),
    .idx_o         (idx),
    .frame_start_o (frame_start)
  );

  logic [NIB_W*DIGITS-1:0] act_q, act_d, shd_q, shd_d;
  logic [DIGITS-1:0]       adp_q, adp_d, sdp_q, sdp_d;
  logic                    pend_q, pend_d;
  logic [NIB_W-1:0]        nib_q, nib_d;
  logic [DIGITS-1:0]       an_q, an_d;
  logic                    dpn_q, dpn_d;
  logic                    tick_q;
  logic [IW-1:0]           hi;
  logic                    lit;

  // A load on the boundary bypasses the shadow so it shows this frame.
  always_comb begin
    act_d  = act_q;
    adp_d  = adp_q;
    shd_d  = load ? value : shd_q;
    sdp_d  = load ? dp : sdp_q;
    pend_d = load ? 1'b1 : pend_q;
    if (frame_start) begin
      pend_d = 1'b0;
      if (load) begin
        act_d = value;
        adp_d = dp;
      end else if (pend_q) begin
        act_d = shd_q;
        adp_d = sdp_q;
      end
    end
  end

  // Highest non-zero nibble; all-zero leaves digit 0 as the top.
  always_comb begin
    hi = '0;
    for (int k = 1; k < DIGITS; k++) begin
      if (act_d[k*NIB_W +: NIB_W] != '0) hi = IW'(k);
    end
  end

  assign lit = en && !(blank_lz && (idx > hi));

  always_comb begin
    nib_d = act_d[{idx, 2'b00} +: NIB_W];
    an_d  = AN_OFF;
    if (lit) an_d[idx] = 1'b0;
    dpn_d = !(lit && adp_d[idx]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_q  <= '0;
      adp_q  <= '0;
      shd_q  <= '0;
      sdp_q  <= '0;
      pend_q <= 1'b0;
      nib_q  <= '0;
      an_q   <= AN_OFF;
      dpn_q  <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      act_q  <= act_d;
      adp_q  <= adp_d;
      shd_q  <= shd_d;
      sdp_q  <= sdp_d;
      pend_q <= pend_d;
      nib_q  <= nib_d;
      an_q   <= an_d;
      dpn_q  <= dpn_d;
      tick_q <= frame_start;
    end
  end

  assign nibble     = nib_q;
  assign an_n       = an_q;
  assign dp_n       = dpn_q;
  assign frame_tick = tick_q;
  assign pending    = pend_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner, DIGITS=4, REFRESH_DIV=4.
// Stimulus queues cycle-tagged expectations; a negedge monitor checks them.
module tb_hex_display_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        en;
  logic        blank_lz;
  logic [3:0]  nibble;
  logic [3:0]  an_n;
  logic        dp_n;
  logic        frame_tick;
  logic        pending;

  hex_display_scanner #(
    .DIGITS      (4),
    .REFRESH_DIV (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .dp         (dp),
    .en         (en),
    .blank_lz   (blank_lz),
    .nibble     (nibble),
    .an_n       (an_n),
    .dp_n       (dp_n),
    .frame_tick (frame_tick),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         k;
    logic [3:0] an;
    logic [3:0] nib;
    logic       dpn;
    logic       ft;
    logic       pend;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   base = 0;
  bit   started = 0;
  int   n_run = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int k, input logic [3:0] an,
                      input logic [3:0] nib, input logic dpn,
                      input logic ft, input logic pend);
    exp_t e;
    e.k = k; e.an = an; e.nib = nib;
    e.dpn = dpn; e.ft = ft; e.pend = pend;
    sb.push_back(e);
  endtask

  task automatic wait_cycle(input int k);
    while (cyc - base < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  int   now;
  exp_t h;
  always @(negedge clk) begin
    if (started) begin
      now = cyc - base;
      while (sb.size() > 0 && sb[0].k <= now) begin
        h = sb.pop_front();
        n_run++;
        if (h.k < now) begin
          n_fail++;
          $display("FAIL missed cyc%0d: check not reached, now %0d", h.k, now);
        end else if ({an_n, nibble, dp_n, frame_tick, pending} !==
                     {h.an, h.nib, h.dpn, h.ft, h.pend}) begin
          n_fail++;
          $display("FAIL cyc%0d: got an_n=%b nib=%h dp_n=%b ft=%b pend=%b, want an_n=%b nib=%h dp_n=%b ft=%b pend=%b",
                   h.k, an_n, nibble, dp_n, frame_tick, pending,
                   h.an, h.nib, h.dpn, h.ft, h.pend);
        end
      end
    end
  end

  initial begin
    #60000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1; load = 0; value = '0; dp = '0; en = 1; blank_lz = 0;
    repeat (3) @(posedge clk);
    #1;
    base = cyc;
    rst = 0;
    started = 1;

    // Reset state and idle scan
    push(0, 4'b1111, 4'h0, 1, 0, 0);
    for (int k = 1; k <= 17; k++) begin
      push(k, ~(4'b0001 << ((k - 1) / 4 % 4)), 4'h0, 1, (k % 16) == 1, 0);
    end

    // Mid-frame load waits for the boundary
    wait_cycle(20);
    load = 1; value = 16'h12AF;
    push(22, 4'b1101, 4'h0, 1, 0, 1);
    push(32, 4'b0111, 4'h0, 1, 0, 1);
    push(33, 4'b1110, 4'hF, 1, 1, 0);
    push(37, 4'b1101, 4'hA, 1, 0, 0);
    push(41, 4'b1011, 4'h2, 1, 0, 0);
    push(45, 4'b0111, 4'h1, 1, 0, 0);
    wait_cycle(21);
    load = 0;

    // Last load before boundary wins
    wait_cycle(50);
    load = 1; value = 16'h1111;
    push(53, 4'b1101, 4'hA, 1, 0, 1);
    push(65, 4'b1110, 4'h2, 1, 1, 0);
    push(69, 4'b1101, 4'h2, 1, 0, 0);
    push(73, 4'b1011, 4'h2, 1, 0, 0);
    push(77, 4'b0111, 4'h2, 1, 0, 0);
    wait_cycle(51);
    load = 0;
    wait_cycle(55);
    load = 1; value = 16'h2222;
    wait_cycle(56);
    load = 0;

    // Leading-zero blanking
    wait_cycle(82);
    blank_lz = 1; load = 1; value = 16'h00A0;
    push(85, 4'b1101, 4'h2, 1, 0, 1);
    push(97, 4'b1110, 4'h0, 1, 1, 0);
    push(101, 4'b1101, 4'hA, 1, 0, 0);
    push(105, 4'b1111, 4'h0, 1, 0, 0);
    push(109, 4'b1111, 4'h0, 1, 0, 0);
    wait_cycle(83);
    load = 0;
    wait_cycle(114);
    load = 1; value = 16'h0000;
    push(129, 4'b1110, 4'h0, 1, 1, 0);
    push(133, 4'b1111, 4'h0, 1, 0, 0);
    push(137, 4'b1111, 4'h0, 1, 0, 0);
    push(141, 4'b1111, 4'h0, 1, 0, 0);
    wait_cycle(115);
    load = 0;
    wait_cycle(142);
    blank_lz = 0;
    push(144, 4'b0111, 4'h0, 1, 0, 0);

    // Load coincident with boundary, dp on digit 2
    wait_cycle(160);
    load = 1; value = 16'h5678; dp = 4'b0100;
    push(161, 4'b1110, 4'h8, 1, 1, 0);
    push(165, 4'b1101, 4'h7, 1, 0, 0);
    push(169, 4'b1011, 4'h6, 0, 0, 0);
    push(172, 4'b1011, 4'h6, 0, 0, 0);
    push(173, 4'b0111, 4'h5, 1, 0, 0);
    wait_cycle(161);
    load = 0;

    // Display disabled for a frame, then reset mid-frame
    wait_cycle(176);
    en = 0; dp = 4'b0000;
    push(177, 4'b1111, 4'h8, 1, 1, 0);
    push(181, 4'b1111, 4'h7, 1, 0, 1);
    push(185, 4'b1111, 4'h6, 1, 0, 1);
    push(189, 4'b1111, 4'h5, 1, 0, 1);
    push(193, 4'b1111, 4'h9, 1, 1, 0);
    wait_cycle(180);
    load = 1; value = 16'h9999;
    wait_cycle(181);
    load = 0;
    wait_cycle(200);
    en = 1; load = 1; value = 16'h3333;
    push(201, 4'b1011, 4'h9, 1, 0, 1);
    push(202, 4'b1011, 4'h9, 1, 0, 1);
    push(203, 4'b1111, 4'h0, 1, 0, 0);
    push(204, 4'b1111, 4'h0, 1, 0, 0);
    push(205, 4'b1110, 4'h0, 1, 1, 0);
    push(221, 4'b1110, 4'h0, 1, 1, 0);
    wait_cycle(201);
    load = 0;
    wait_cycle(202);
    rst = 1;
    wait_cycle(204);
    rst = 0;

    wait_cycle(225);
    #6;
    if (sb.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL leftover: %0d checks never reached, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
- Time-multiplexes a DIGITS-wide hex value onto a common-anode 7-segment bank.
- Sits directly upstream of the 4-bit-to-7-segment decoder: drives the decoder's nibble input and the per-digit anode/DP lines.
- Loads are double-buffered: a new value only takes effect at a frame boundary, so a displayed frame never mixes old and new digits.

Parameters:
- DIGITS, 4, number of multiplexed digits (2..8).
- REFRESH_DIV, 50000, clock cycles each digit stays lit (>=2).
- CW, $clog2(REFRESH_DIV), refresh counter width (derived; not overridden).
- IW, $clog2(DIGITS), digit index width (derived).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- load  in  1  one-cycle strobe; capture value/dp into the shadow buffer.
- value  in  4*DIGITS  hex value; nibble k is shown on digit k (k=0 rightmost).
- dp  in  DIGITS  decimal point request per digit, 1=lit.
- en  in  1  display enable; 0 blanks all anodes, counters keep running.
- blank_lz  in  1  1=suppress leading zero digits.
- nibble  out  4  to the decoder input.
- an_n  out  DIGITS  anode enables, active-low, one-hot-low when lit.
- dp_n  out  1  decimal point, active-low.
- frame_tick  out  1  one-cycle pulse when digit 0 is entered.
- pending  out  1  shadow holds a value not yet displayed.

Behaviour:
- Interface fixed: one clock, clk; reset rst is synchronous and active-high.
- Reset values: refresh counter 0, digit index 0, active value/dp 0, shadow 0, pending 0, nibble 0, an_n all 1, dp_n 1, frame_tick 0.
- Refresh counter counts 0..REFRESH_DIV-1 and wraps.
- At the terminal count the digit index increments, wrapping DIGITS-1 -> 0.
- A frame boundary is the cycle in which the index wraps to 0, or the first cycle after reset.
- Load:
  - On load=1, value/dp are written to the shadow at that edge and pending is set to 1.
  - Repeated loads before a boundary: the last one wins.
- Frame boundary:
  - If pending=1, active <= shadow and pending <= 0.
  - If load coincides with a boundary, the incoming value/dp go straight to active, shadow is also updated, and pending stays 0.
- Outputs are registered, with 1-cycle latency from the index change. The value shown for digit i comes from the active value after any boundary update in that same cycle.
  - nibble = active[4i+3:4i].
  - dp_n = ~active_dp[i].
  - an_n = all 1 except bit i = 0.
- Leading-zero blanking (blank_lz=1):
  - Digit i is blanked (an_n[i]=1) when i > index of the highest non-zero nibble of active.
  - Digit 0 is never blanked.
  - A blanked digit with dp set is still blanked.
- en=0: an_n all 1 and dp_n=1. Index, counter, load and buffer logic are unaffected.
- frame_tick is registered and aligned with the first output cycle of digit 0.
- Reset mid-frame returns everything to the reset values on the next edge. Any pending shadow is discarded.
- First lit output: cycle 1 after rst deasserts, showing digit 0 of active=0, i.e. nibble 0, an_n=...1110.

Decomposition:
- Shared package: decoder nibble width (4), DIGITS default, and an active-low ALL_OFF anode constant helper.
- One natural sub-module, scan_timer: the refresh counter plus digit index, producing idx and frame_start.
- Leading-zero detection and buffering stay in the top module.
- The decoder is instantiated by the parent, not inside this block.

Test Plan:
- Reset then idle with REFRESH_DIV=4, DIGITS=4, en=1 -> an_n cycles 1110,1101,1011,0111 every 4 cycles, nibble=0, frame_tick every 16 cycles.
- load value=16'h12AF mid-frame -> pending=1; digits still show 0 until the next boundary, then digit0..3 show F,A,2,1 and pending=0.
- load 16'h1111, then 16'h2222 before the boundary -> next frame shows only 2222; no frame ever shows 1111.
- load 16'h00A0 with blank_lz=1 -> digits 3,2 blanked (an_n bit high), digit1=A, digit0=0 lit; with value 0, only digit0 lit.
- load coincident with the frame-boundary cycle, dp=4'b0100 -> value shown that frame, pending stays 0, dp_n=0 only while digit 2 is lit.
- en=0 for a full frame, then rst asserted mid-frame -> an_n all 1 during en=0 while frame_tick continues; after rst, active=0, pending=0, outputs at reset values.
